mem_bus_arbiter: RTL and testbench

- Two-requester arbiter sharing the single core-side AXI4 memory master between the instruction fetch path (ifu/icache refill, read-only, bursts) and the LSU (single-beat read or write).
- Sits between ifu/icache + lsu and the SoC AXI crossbar.
- Owns grant sequencing, address/data capture, channel handshakes and response routing.
- One transaction in flight at a time.

---
 rtl/mem_bus_arbiter_pkg.sv | 39 +++
 rtl/mem_bus_arbiter_pick.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4 memory bus arbiter.
// Round-robin arbitration is selected with the MEM_ARB_RR_EN macro.
package mem_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_AR = 3'd1,
        ST_IF_R  = 3'd2,
        ST_LS_AR = 3'd3,
        ST_LS_R  = 3'd4,
        ST_LS_W  = 3'd5,
        ST_LS_B  = 3'd6
    } arb_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } requester_e;

    // AXI size encoding: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned data_bytes);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == data_bytes) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner selection between fetch and LSU requests.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise the LSU has fixed priority.
module mem_bus_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
`ifdef MEM_ARB_RR_EN
    input  requester_e last_gnt,
`endif
    output logic       pick_ifu,
    output logic       pick_lsu
);

    always_comb begin
        pick_lsu = lsu_req;
        pick_ifu = ifu_req && !lsu_req;
`ifdef MEM_ARB_RR_EN
        // On a collision the requester that did not win last time goes first.
        if (ifu_req && lsu_req) begin
            pick_lsu = (last_gnt == REQ_IFU);
            pick_ifu = (last_gnt == REQ_LSU);
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one AXI4 master between instruction fetch (read bursts) and the LSU
// (single-beat read/write), one transaction at a time. Optional macro: MEM_ARB_RR_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic [LEN_W-1:0]    ifu_len,
    output logic                ifu_gnt,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rlast,
    output logic                ifu_err,

    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_gnt,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [LEN_W-1:0]    m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,

    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
);

    localparam logic [2:0] ARSIZE = axi_size(DATA_W / 8);

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                overrun_q, overrun_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick_ifu, pick_lsu;
    logic                lsu_req_eff;
    logic                beat_err;
    logic                aw_ok, w_ok;

    // The LSU only drops its request after seeing lsu_done, so ignore it in that cycle.
    assign lsu_req_eff = lsu_req && !done_q;

`ifdef MEM_ARB_RR_EN
    requester_e last_gnt_q, last_gnt_d;

    mem_bus_arb_pick u_pick (
        .ifu_req  (ifu_req),
        .lsu_req  (lsu_req_eff),
        .last_gnt (last_gnt_q),
        .pick_ifu (pick_ifu),
        .pick_lsu (pick_lsu)
    );
`else
    mem_bus_arb_pick u_pick (
        .ifu_req  (ifu_req),
        .lsu_req  (lsu_req_eff),
        .pick_ifu (pick_ifu),
        .pick_lsu (pick_lsu)
    );
`endif

    // NOTE: async reset clears the whole (small) datapath too, so no X ever reaches the bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= REQ_IFU;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no latches are inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        beat_err   = (m_rresp != RESP_OKAY);
        aw_ok      = aw_done_q || m_awready;
        w_ok       = w_done_q || m_wready;

        ifu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;
        ifu_rvalid = 1'b0;
        ifu_rlast  = 1'b0;
        ifu_err    = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                overrun_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (pick_lsu) begin
                    lsu_gnt = 1'b1;
                    addr_d  = lsu_addr;
                    len_d   = '0;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                    state_d = lsu_we ? ST_LS_W : ST_LS_AR;
`ifdef MEM_ARB_RR_EN
                    last_gnt_d = REQ_LSU;
`endif
                end else if (pick_ifu) begin
                    ifu_gnt = 1'b1;
                    addr_d  = ifu_addr;
                    len_d   = ifu_len;
                    state_d = ST_IF_AR;
`ifdef MEM_ARB_RR_EN
                    last_gnt_d = REQ_IFU;
`endif
                end
            end

            ST_IF_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_IF_R;
            end

            ST_IF_R: begin
                m_rready   = 1'b1;
                ifu_rvalid = m_rvalid;
                ifu_rlast  = m_rvalid && m_rlast;
                if (m_rvalid) begin
                    if (m_rlast) begin
                        // Short or long bursts are flagged on the closing beat.
                        ifu_err = beat_err || overrun_q || (cnt_q != len_q);
                        state_d = ST_IDLE;
                    end else begin
                        ifu_err = beat_err;
                        if (cnt_q == len_q) overrun_d = 1'b1;
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end

            ST_LS_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_LS_R;
            end

            ST_LS_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    err_d   = beat_err;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_LS_W: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) state_d = ST_LS_B;
            end

            ST_LS_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    err_d   = (m_bresp != RESP_OKAY);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign ifu_rdata = m_rdata;
    assign lsu_done  = done_q;
    assign lsu_err   = err_q;
    assign lsu_rdata = rdata_q;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = ARSIZE;
    assign m_arburst = BURST_INCR;
    assign m_awaddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wlast   = 1'b1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch bursts, LSU read/write, collisions, errors, reset.
// Build with MEM_ARB_RR_EN defined to check the round-robin collision outcome instead.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clock, reset;
    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic [LW-1:0] ifu_len;
    logic          ifu_gnt, ifu_rvalid, ifu_rlast, ifu_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req, lsu_we;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [DW/8-1:0] lsu_wstrb;
    logic          lsu_gnt, lsu_done, lsu_err;
    logic [DW-1:0] lsu_rdata;
    logic          m_arvalid, m_arready;
    logic [AW-1:0] m_araddr;
    logic [LW-1:0] m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_rvalid, m_rready, m_rlast;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_awvalid, m_awready;
    logic [AW-1:0] m_awaddr;
    logic          m_wvalid, m_wready, m_wlast;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic          m_bvalid, m_bready;
    logic [1:0]    m_bresp;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_len(ifu_len), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a fetch in IDLE, check grant and AR phase, accept AR; ends in IF_R.
    task automatic fetch_grant(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l);
        ifu_req  = 1'b1;
        ifu_addr = a;
        ifu_len  = l;
        #1;
        check({tag, ".gnt"}, ifu_gnt, 1'b1);
        check({tag, ".ar_early"}, m_arvalid, 1'b0);
        step();
        check({tag, ".arvalid"}, m_arvalid, 1'b1);
        check({tag, ".araddr"}, m_araddr, a);
        check({tag, ".arlen"}, m_arlen, l);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
    endtask

    // Present one R beat in IF_R and check what the fetch side sees.
    task automatic r_beat(input string tag, input logic [DW-1:0] d, input logic [1:0] resp,
                          input logic last, input logic exp_err);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rresp  = resp;
        m_rlast  = last;
        #1;
        check({tag, ".rvalid"}, ifu_rvalid, 1'b1);
        check({tag, ".rdata"}, ifu_rdata, d);
        check({tag, ".rlast"}, ifu_rlast, last);
        check({tag, ".err"}, ifu_err, exp_err);
        step();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = RESP_OKAY;
    endtask

    // Complete an LSU read from LS_AR: accept AR, return one beat, check the done cycle.
    task automatic lsu_read_finish(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, ".arvalid"}, m_arvalid, 1'b1);
        check({tag, ".araddr"}, m_araddr, a);
        check({tag, ".arlen"}, m_arlen, 8'd0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = d;
        m_rresp   = RESP_OKAY;
        m_rlast   = 1'b1;
        #1;
        check({tag, ".rready"}, m_rready, 1'b1);
        check({tag, ".no_ifu_fwd"}, ifu_rvalid, 1'b0);
        step();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check({tag, ".done"}, lsu_done, 1'b1);
        check({tag, ".rdata"}, lsu_rdata, d);
        check({tag, ".err"}, lsu_err, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ifu_req = 1'b0; ifu_addr = '0; ifu_len = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
        #1 reset = 1'b1;
        #2;
        check("rst.arvalid", m_arvalid, 1'b0);
        check("rst.awvalid", m_awvalid, 1'b0);
        check("rst.wvalid",  m_wvalid, 1'b0);
        check("rst.rready",  m_rready, 1'b0);
        check("rst.bready",  m_bready, 1'b0);
        check("rst.lsu_done", lsu_done, 1'b0);
        check("rst.lsu_err", lsu_err, 1'b0);
        check("rst.arsize",  m_arsize, 3'd2);
        check("rst.arburst", m_arburst, 2'b01);
        check("rst.wlast",   m_wlast, 1'b1);
        step();
        step();
        reset = 1'b0;
        step();

        // Single 4-beat fetch.
        fetch_grant("f1", 32'h3000_0000, 8'd3);
        check("f1.rready", m_rready, 1'b1);
        for (int i = 0; i < 4; i++) r_beat("f1.beat", 32'hA0 + i, RESP_OKAY, i == 3, 1'b0);
        ifu_req = 1'b0;
        #1;
        check("f1.idle_rready", m_rready, 1'b0);
        check("f1.idle_gnt", ifu_gnt, 1'b0);
        step();

        // Collision: LSU read wins, IFU granted in the LSU done cycle.
        ifu_req = 1'b1; ifu_addr = 32'h3000_0100; ifu_len = 8'd0;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0010;
        #1;
        check("col.lsu_gnt", lsu_gnt, 1'b1);
        check("col.ifu_gnt", ifu_gnt, 1'b0);
        step();
        check("col.ifu_gnt_wait", ifu_gnt, 1'b0);
        lsu_read_finish("col.rd", 32'h8000_0010, 32'h1234_5678);
        check("col.no_regrant", lsu_gnt, 1'b0);
        check("col.ifu_gnt2", ifu_gnt, 1'b1);
        lsu_req = 1'b0;
        step();
        check("col.done_pulse", lsu_done, 1'b0);
        check("col.f_araddr", m_araddr, 32'h3000_0100);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        r_beat("col.f", 32'h55, RESP_OKAY, 1'b1, 1'b0);
        ifu_req = 1'b0;
        step();

        // LSU write, AW accepted three cycles before W.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_0004;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        #1;
        check("wr.gnt", lsu_gnt, 1'b1);
        step();
        check("wr.awvalid", m_awvalid, 1'b1);
        check("wr.wvalid", m_wvalid, 1'b1);
        check("wr.awaddr", m_awaddr, 32'h8000_0004);
        check("wr.wdata", m_wdata, 32'hDEAD_BEEF);
        check("wr.wstrb", m_wstrb, 4'hF);
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr.aw_dropped", m_awvalid, 1'b0);
            check("wr.w_held", m_wvalid, 1'b1);
            if (i == 2) m_wready = 1'b1;
            else step();
        end
        step();
        m_wready = 1'b0;
        check("wr.w_dropped", m_wvalid, 1'b0);
        check("wr.bready", m_bready, 1'b1);
        m_bvalid = 1'b1; m_bresp = RESP_OKAY;
        step();
        m_bvalid = 1'b0;
        check("wr.done", lsu_done, 1'b1);
        check("wr.err", lsu_err, 1'b0);
        lsu_req = 1'b0;
        step();
        check("wr.done_off", lsu_done, 1'b0);

        // SLVERR on the second beat of a two-beat fetch.
        fetch_grant("e1", 32'h3000_0200, 8'd1);
        r_beat("e1.b1", 32'hB0, RESP_OKAY, 1'b0, 1'b0);
        r_beat("e1.b2", 32'hB1, RESP_SLVERR, 1'b1, 1'b1);
        ifu_req = 1'b0;
        step();

        // Early rlast: len=2 but only two beats.
        fetch_grant("e2", 32'h3000_0300, 8'd2);
        r_beat("e2.b1", 32'hC0, RESP_OKAY, 1'b0, 1'b0);
        r_beat("e2.b2", 32'hC1, RESP_OKAY, 1'b1, 1'b1);
        ifu_req = 1'b0;
        step();

        // Overlong burst: len=0 but two beats; the extra beat is drained.
        fetch_grant("e3", 32'h3000_0400, 8'd0);
        r_beat("e3.b1", 32'hD0, RESP_OKAY, 1'b0, 1'b0);
        r_beat("e3.b2", 32'hD1, RESP_OKAY, 1'b1, 1'b1);
        ifu_req = 1'b0;
        step();

        // DECERR on a write; AW and W accepted in the same cycle.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h8000_0008;
        lsu_wdata = 32'h0000_00FF; lsu_wstrb = 4'h1;
        step();
        m_awready = 1'b1; m_wready = 1'b1;
        step();
        m_awready = 1'b0; m_wready = 1'b0;
        check("e4.bready", m_bready, 1'b1);
        m_bvalid = 1'b1; m_bresp = RESP_DECERR;
        step();
        m_bvalid = 1'b0; m_bresp = RESP_OKAY;
        check("e4.done", lsu_done, 1'b1);
        check("e4.err", lsu_err, 1'b1);
        lsu_req = 1'b0;
        step();

        // Asynchronous reset in the middle of a fetch burst.
        fetch_grant("rs", 32'h3000_0020, 8'd3);
        r_beat("rs.b1", 32'hE0, RESP_OKAY, 1'b0, 1'b0);
        m_rvalid = 1'b1; m_rdata = 32'hE1;
        #3 reset = 1'b1;
        #1;
        check("rs.rvalid", ifu_rvalid, 1'b0);
        check("rs.rready", m_rready, 1'b0);
        check("rs.arvalid", m_arvalid, 1'b0);
        m_rvalid = 1'b0;
        ifu_req  = 1'b0;
        #1 reset = 1'b0;
        step();
        check("rs.idle", m_arvalid, 1'b0);
        fetch_grant("rs.again", 32'h3000_0040, 8'd0);
        r_beat("rs.again", 32'hF0, RESP_OKAY, 1'b1, 1'b0);
        ifu_req = 1'b0;
        step();

        // Collision right after an LSU grant: round-robin favours the IFU.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0020;
        step();
        lsu_read_finish("rr.pre", 32'h8000_0020, 32'h0BAD_F00D);
        lsu_req = 1'b0;
        step();
        ifu_req = 1'b1; ifu_addr = 32'h3000_0500; ifu_len = 8'd0;
        lsu_req = 1'b1; lsu_addr = 32'h8000_0030;
        #1;
`ifdef MEM_ARB_RR_EN
        check("rr.ifu_first", ifu_gnt, 1'b1);
        check("rr.lsu_wait", lsu_gnt, 1'b0);
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        r_beat("rr.f", 32'h66, RESP_OKAY, 1'b1, 1'b0);
        ifu_req = 1'b0;
        #1;
        check("rr.lsu_next", lsu_gnt, 1'b1);
        step();
        lsu_read_finish("rr.rd", 32'h8000_0030, 32'h7777_0000);
        lsu_req = 1'b0;
`else
        check("fx.lsu_first", lsu_gnt, 1'b1);
        check("fx.ifu_wait", ifu_gnt, 1'b0);
        step();
        lsu_read_finish("fx.rd", 32'h8000_0030, 32'h7777_0000);
        check("fx.ifu_next", ifu_gnt, 1'b1);
        lsu_req = 1'b0;
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        r_beat("fx.f", 32'h66, RESP_OKAY, 1'b1, 1'b0);
        ifu_req = 1'b0;
`endif
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
